mul_arb_ctrl: RTL and testbench
===============================

MUL_ARB_CTRL -- requirements
Module: mul_arb_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 1: the number of cycles from mul_a/mul_b being registered until mul_pro is valid; legal range 1..7.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge clk.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req0_valid, input, 1 bit: requester 0 presents operands.
REQ-005 SHALL have port req0_ready, output, 1 bit: requester 0 operands accepted this cycle.
REQ-006 SHALL have ports req0_a and req0_b, input, 16 bits each: requester 0 operands.
REQ-007 SHALL have ports req1_valid, req1_ready, req1_a and req1_b, with the same directions, widths and meanings as the requester 0 ports.
REQ-008 SHALL have port mul_a, output, 16 bits: registered operand A driven to the shared multiplier.
REQ-009 SHALL have port mul_b, output, 16 bits: registered operand B driven to the shared multiplier.
REQ-010 SHALL have port mul_pro, input, 32 bits: product returned by the shared multiplier.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is held.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-013 SHALL have port rsp_id, output, 1 bit: index of the requester that owns the response.
REQ-014 SHALL have port rsp_pro, output, 32 bits: the registered product.

Function
REQ-015 SHALL implement the states IDLE, MUL and HOLD.
REQ-016 In IDLE with at least one valid request, SHALL grant exactly one requester, assert its ready combinationally in that cycle, register its operands into mul_a/mul_b, store its index into rsp_id, and go to MUL.
REQ-017 SHALL use round-robin arbitration: a single valid request is granted; when both are valid, the requester not stored in last_grant wins; last_grant updates on every grant.
REQ-018 In MUL, a 3-bit counter SHALL count MUL_LAT cycles; in the last one, mul_pro SHALL be captured into rsp_pro, and the block SHALL go to HOLD with rsp_valid = 1 from the next cycle.
REQ-019 Accept latency SHALL be fixed: an accept in cycle T gives rsp_valid high in cycle T+MUL_LAT+1.
REQ-020 In HOLD, rsp_valid, rsp_id and rsp_pro SHALL stay stable until rsp_ready = 1.
REQ-021 In HOLD with rsp_ready = 1, SHALL clear rsp_valid; if a request is also valid that cycle, SHALL grant it per REQ-016/017 and go directly to MUL, otherwise SHALL go to IDLE.
REQ-022 req0_ready and req1_ready SHALL be 0 in MUL, and in HOLD without rsp_ready; they are never both 1.
REQ-023 mul_a/mul_b SHALL hold their last operands until the next grant; they are not cleared.
REQ-024 The controller SHALL pass mul_pro through bit-exact without reinterpreting its sign or width; no arithmetic is done in this block.
REQ-025 Requester valid/operands SHALL be ignored when that requester's ready is 0; no request is ever queued internally.

Reset
REQ-026 With rst = 1 at a clock edge, SHALL force state to IDLE, the counter to 0 and last_grant to 1, so requester 0 wins the first tie.
REQ-027 On reset, outputs SHALL be mul_a = 0, mul_b = 0, rsp_valid = 0, rsp_id = 0 and rsp_pro = 0; req0_ready and req1_ready are 0 while rst = 1.
REQ-028 Reset during MUL or HOLD SHALL discard the in-flight operation with no response issued.

Configuration
REQ-029 Macro MUL_ARB_ZERO_BYPASS_EN: when defined, a grant with either operand equal to 0x0000 SHALL skip MUL, leave mul_a/mul_b unchanged, load rsp_pro = 0 and go straight to HOLD, so rsp_valid is high at T+1.
REQ-030 When MUL_ARB_ZERO_BYPASS_EN is undefined, every grant SHALL follow REQ-018/019 regardless of operand value.

Verification (bench model: mul_pro = signed(mul_a) * signed(mul_b), delayed MUL_LAT cycles)
REQ-031 With MUL_LAT = 1, req0 sends a = 0x0003, b = 0x0005 in cycle T -> req0_ready is 1 at T, rsp_valid is 1 at T+2, rsp_id = 0, rsp_pro = 0x0000000F.
REQ-032 After reset, both valid: req0 sends 0xFFFF*0x0002 and req1 sends 0x0004*0x0004, with rsp_ready tied to 1 -> responses are id 0 with 0xFFFFFFFE, then id 1 with 0x00000010.
REQ-033 With MUL_LAT = 3, rsp_ready held 0 for 5 cycles after rsp_valid rises -> rsp_valid, rsp_id and rsp_pro stay stable and both readys stay 0; then rsp_ready = 1 with req1_valid = 1 -> req1_ready = 1 in that same cycle.
REQ-034 rst asserted one cycle into MUL -> no rsp_valid; all outputs are 0 the next cycle; the next tie grants req0.
REQ-035 With MUL_ARB_ZERO_BYPASS_EN defined, a = 0x0000, b = 0x1234 accepted at T -> rsp_valid at T+1 with rsp_pro = 0 and mul_a/mul_b unchanged; with the macro undefined -> rsp_valid at T+MUL_LAT+1.

Source files
------------

// File: rtl/mul_arb_ctrl.sv
// ----------------------------------------------------------------------------
// mul_arb_ctrl
//
// Shares one external multiplier between two requesters. The controller grants
// one requester at a time (round-robin on ties), registers its operands onto
// mul_a/mul_b, waits MUL_LAT cycles for the multiplier and then holds the
// product on the response channel until it is consumed. Only one operation is
// ever in flight, and nothing is queued.
//
// Parameters
//   MUL_LAT    cycles from mul_a/mul_b being registered until mul_pro is valid
//              (legal range 1..7)
//
// Optional feature
//   MUL_ARB_ZERO_BYPASS_EN  when defined, a grant with either operand equal to
//              zero skips the multiplier, leaves mul_a/mul_b untouched and
//              answers with a product of zero one cycle after the accept.
//
// Ports
//   clk                 clock, all flops on the rising edge
//   rst                 synchronous active-high reset
//   req0_valid/ready    requester 0 handshake (ready is combinational)
//   req0_a, req0_b      requester 0 operands, 16 bits each
//   req1_*              same as requester 0
//   mul_a, mul_b        registered operands to the shared multiplier
//   mul_pro             32-bit product from the shared multiplier
//   rsp_valid/ready     response handshake
//   rsp_id              requester that owns the response
//   rsp_pro             registered product, passed through bit-exact
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no operation in flight, waiting for a request
// MUL     | operands on mul_a/mul_b, counting down the multiplier latency
// HOLD    | product registered, rsp_valid high until rsp_ready
// ----------------------------------------------------------------------------
module mul_arb_ctrl #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,

    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [31:0] mul_pro,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_pro
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Down-counter load: the MUL state lasts MUL_LAT cycles, terminal count 0.
    localparam logic [2:0] CNT_LOAD = 3'(MUL_LAT - 1);

`ifdef MUL_ARB_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic        last_grant;

    logic        can_grant;
    logic        gnt0;
    logic        gnt1;
    logic        gnt_any;
    logic [15:0] gnt_a;
    logic [15:0] gnt_b;
    logic        gnt_zero;

    // ------------------------------------------------------------------
    // Arbitration. A grant is possible in IDLE, or in HOLD in the same
    // cycle the current response is consumed. Readys are held low during
    // reset so no requester believes it was accepted.
    // ------------------------------------------------------------------
    always_comb begin
        can_grant = 1'b0;
        if (!rst) begin
            can_grant = (state == ST_IDLE) || ((state == ST_HOLD) && rsp_ready);
        end

        // On a tie the requester that did not win last time goes first.
        gnt0 = can_grant && req0_valid && (!req1_valid || last_grant);
        gnt1 = can_grant && req1_valid && (!req0_valid || !last_grant);
        gnt_any = gnt0 || gnt1;

        gnt_a = gnt1 ? req1_a : req0_a;
        gnt_b = gnt1 ? req1_b : req0_b;

        gnt_zero = ZERO_BYPASS && ((gnt_a == 16'h0000) || (gnt_b == 16'h0000));
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // ------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            last_grant <= 1'b1;
            mul_a      <= 16'h0000;
            mul_b      <= 16'h0000;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_pro    <= 32'h0000_0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        last_grant <= gnt1;
                        rsp_id     <= gnt1;
                        if (gnt_zero) begin
                            rsp_pro   <= 32'h0000_0000;
                            rsp_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end else begin
                            mul_a <= gnt_a;
                            mul_b <= gnt_b;
                            cnt   <= CNT_LOAD;
                            state <= ST_MUL;
                        end
                    end
                end

                ST_MUL: begin
                    if (cnt == 3'd0) begin
                        rsp_pro   <= mul_pro;
                        rsp_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end

                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (gnt_any) begin
                            // rsp_id may change now: the old response is
                            // consumed at this same edge.
                            last_grant <= gnt1;
                            rsp_id     <= gnt1;
                            if (gnt_zero) begin
                                rsp_pro   <= 32'h0000_0000;
                                rsp_valid <= 1'b1;
                                state     <= ST_HOLD;
                            end else begin
                                mul_a <= gnt_a;
                                mul_b <= gnt_b;
                                cnt   <= CNT_LOAD;
                                state <= ST_MUL;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arb_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mul_arb_ctrl
//
// Two instances: unit 0 with MUL_LAT = 1 and unit 1 with MUL_LAT = 3, each
// with its own signed multiplier model delaying the product MUL_LAT cycles
// after mul_a/mul_b are registered. Expected responses go into a per-unit
// queue at accept time and are popped when a response is consumed.
// Inputs are driven 1 time unit after the rising edge; registered outputs are
// sampled at that point and combinational readys 1 unit later.
// ----------------------------------------------------------------------------
module tb_mul_arb_ctrl;

`ifdef MUL_ARB_ZERO_BYPASS_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0_valid [2];
    logic        req0_ready [2];
    logic [15:0] req0_a     [2];
    logic [15:0] req0_b     [2];
    logic        req1_valid [2];
    logic        req1_ready [2];
    logic [15:0] req1_a     [2];
    logic [15:0] req1_b     [2];
    logic [15:0] mul_a      [2];
    logic [15:0] mul_b      [2];
    logic [31:0] mul_pro    [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic        rsp_id     [2];
    logic [31:0] rsp_pro    [2];

    int checks = 0;
    int errors = 0;

    logic [32:0] sb0 [$];
    logic [32:0] sb1 [$];

    for (genvar g = 0; g < 2; g++) begin : u_g
        localparam int LAT = (g == 0) ? 1 : 3;

        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic        [31:0] prod;
        logic        [31:0] pipe [1:7];

        assign sa   = {{16{mul_a[g][15]}}, mul_a[g]};
        assign sb   = {{16{mul_b[g][15]}}, mul_b[g]};
        assign prod = sa * sb;

        always @(posedge clk) begin
            pipe[1] <= prod;
            for (int i = 2; i <= 7; i++) pipe[i] <= pipe[i-1];
        end

        if (LAT == 1) begin : g_comb
            assign mul_pro[g] = prod;
        end else begin : g_pipe
            assign mul_pro[g] = pipe[LAT-1];
        end

        mul_arb_ctrl #(.MUL_LAT(LAT)) dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (req0_valid[g]),
            .req0_ready (req0_ready[g]),
            .req0_a     (req0_a[g]),
            .req0_b     (req0_b[g]),
            .req1_valid (req1_valid[g]),
            .req1_ready (req1_ready[g]),
            .req1_a     (req1_a[g]),
            .req1_b     (req1_b[g]),
            .mul_a      (mul_a[g]),
            .mul_b      (mul_b[g]),
            .mul_pro    (mul_pro[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_id     (rsp_id[g]),
            .rsp_pro    (rsp_pro[g])
        );
    end

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] xa;
        logic signed [31:0] xb;
        xa = {{16{a[15]}}, a};
        xb = {{16{b[15]}}, b};
        return xa * xb;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input int u, input logic id, input logic [31:0] p);
        if (u == 0) sb0.push_back({id, p});
        else        sb1.push_back({id, p});
    endtask

    task automatic sb_clear(input int u);
        if (u == 0) sb0.delete();
        else        sb1.delete();
    endtask

    task automatic sb_check(input int u, input string name);
        logic [32:0] e;
        int n;
        n = (u == 0) ? sb0.size() : sb1.size();
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL %s u%0d: unexpected response id %0d pro %h, nothing expected",
                     name, u, rsp_id[u], rsp_pro[u]);
        end else begin
            e = (u == 0) ? sb0.pop_front() : sb1.pop_front();
            if ({rsp_id[u], rsp_pro[u]} !== e) begin
                errors++;
                $display("FAIL %s u%0d: got id %0d pro %h, expected id %0d pro %h",
                         name, u, rsp_id[u], rsp_pro[u], e[32], e[31:0]);
            end
        end
    endtask

    // Runs cycles until nrsp responses are consumed; pushes accepted
    // requests into the scoreboard when push_en is set.
    task automatic drain(input int u, input int nrsp, input int budget,
                         input bit push_en, input string name);
        int got;
        bit clr0;
        bit clr1;
        got = 0;
        for (int c = 0; c < budget && got < nrsp; c++) begin
            #1;
            clr0 = 1'b0;
            clr1 = 1'b0;
            checks++;
            if (req0_ready[u] && req1_ready[u]) begin
                errors++;
                $display("FAIL %s u%0d: both readys high", name, u);
            end
            if (rsp_valid[u] && rsp_ready[u]) begin
                sb_check(u, name);
                got++;
            end
            if (req0_valid[u] && req0_ready[u]) begin
                if (push_en) sb_push(u, 1'b0, model(req0_a[u], req0_b[u]));
                clr0 = 1'b1;
            end
            if (req1_valid[u] && req1_ready[u]) begin
                if (push_en) sb_push(u, 1'b1, model(req1_a[u], req1_b[u]));
                clr1 = 1'b1;
            end
            cyc();
            if (clr0) req0_valid[u] = 1'b0;
            if (clr1) req1_valid[u] = 1'b0;
        end
        checks++;
        if (got != nrsp) begin
            errors++;
            $display("FAIL %s u%0d: responses got %0d expected %0d", name, u, got, nrsp);
        end
    endtask

    // Single accept from requester r; checks ready, response latency (in
    // cycles after the accept cycle) and content, then consumes it.
    task automatic accept_timed(input int u, input logic r, input logic [15:0] a,
                                input logic [15:0] b, input int exp_lat, input string name);
        int n;
        rsp_ready[u] = 1'b0;
        if (r) begin
            req1_valid[u] = 1'b1; req1_a[u] = a; req1_b[u] = b;
        end else begin
            req0_valid[u] = 1'b1; req0_a[u] = a; req0_b[u] = b;
        end
        #1;
        checks++;
        if ((r ? req1_ready[u] : req0_ready[u]) !== 1'b1) begin
            errors++;
            $display("FAIL %s u%0d: ready got 0 expected 1", name, u);
        end
        sb_push(u, r, model(a, b));
        cyc();
        req0_valid[u] = 1'b0;
        req1_valid[u] = 1'b0;
        n = 1;
        while (n <= 16 && !rsp_valid[u]) begin
            cyc();
            n++;
        end
        checks++;
        if (n != exp_lat) begin
            errors++;
            $display("FAIL %s u%0d: latency got %0d expected %0d", name, u, n, exp_lat);
        end
        if (rsp_valid[u]) sb_check(u, name);
        else sb_clear(u);
        rsp_ready[u] = 1'b1;
        cyc();
        rsp_ready[u] = 1'b0;
        checks++;
        if (rsp_valid[u] !== 1'b0) begin
            errors++;
            $display("FAIL %s u%0d: rsp_valid after consume got %0d expected 0",
                     name, u, rsp_valid[u]);
        end
    endtask

    task automatic check_zero_out(input int u, input string name);
        checks++;
        if (mul_a[u] !== 16'h0 || mul_b[u] !== 16'h0 || rsp_valid[u] !== 1'b0 ||
            rsp_id[u] !== 1'b0 || rsp_pro[u] !== 32'h0) begin
            errors++;
            $display("FAIL %s u%0d: got mul_a %h mul_b %h rsp_valid %0d rsp_id %0d rsp_pro %h, expected all 0",
                     name, u, mul_a[u], mul_b[u], rsp_valid[u], rsp_id[u], rsp_pro[u]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req0_valid[u] = 1'b1; req0_a[u] = 16'h1111; req0_b[u] = 16'h2222;
            req1_valid[u] = 1'b1; req1_a[u] = 16'h3333; req1_b[u] = 16'h4444;
            rsp_ready[u]  = 1'b1;
        end
        repeat (3) cyc();
        #1;
        for (int u = 0; u < 2; u++) begin
            check_zero_out(u, "reset_outputs");
            checks++;
            if (req0_ready[u] !== 1'b0 || req1_ready[u] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready u%0d: got %0d/%0d expected 0/0",
                         u, req0_ready[u], req1_ready[u]);
            end
            req0_valid[u] = 1'b0;
            req1_valid[u] = 1'b0;
            rsp_ready[u]  = 1'b0;
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        accept_timed(0, 1'b0, 16'h0003, 16'h0005, 2, "single_lat1");
        checks++;
        if (rsp_pro[0] !== 32'h0000_000F) begin
            errors++;
            $display("FAIL single_lat1_pro: got %h expected 0000000f", rsp_pro[0]);
        end
        accept_timed(1, 1'b1, 16'h8000, 16'h0002, 4, "single_lat3");
    endtask

    task automatic test_zero_operand();
        logic [15:0] pa;
        logic [15:0] pb;
        for (int u = 0; u < 2; u++) begin
            pa = mul_a[u];
            pb = mul_b[u];
            accept_timed(u, 1'b1, 16'h0000, 16'h1234, ZB ? 1 : ((u == 0) ? 2 : 4), "zero_op");
            checks++;
            if (mul_a[u] !== (ZB ? pa : 16'h0000) || mul_b[u] !== (ZB ? pb : 16'h1234)) begin
                errors++;
                $display("FAIL zero_op_operands u%0d: got %h/%h expected %h/%h", u,
                         mul_a[u], mul_b[u], ZB ? pa : 16'h0000, ZB ? pb : 16'h1234);
            end
        end
    endtask

    task automatic test_tie_rr();
        do_reset();
        rsp_ready[0]  = 1'b1;
        req0_valid[0] = 1'b1; req0_a[0] = 16'hFFFF; req0_b[0] = 16'h0002;
        req1_valid[0] = 1'b1; req1_a[0] = 16'h0004; req1_b[0] = 16'h0004;
        #1;
        checks++;
        if (req0_ready[0] !== 1'b1 || req1_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL tie_first_grant: got %0d/%0d expected 1/0",
                     req0_ready[0], req1_ready[0]);
        end
        sb_push(0, 1'b0, 32'hFFFF_FFFE);
        sb_push(0, 1'b1, 32'h0000_0010);
        drain(0, 2, 30, 1'b0, "tie_rr");
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_hold_stall();
        int n;
        logic        sid;
        logic [31:0] spro;
        rsp_ready[1]  = 1'b0;
        req0_valid[1] = 1'b1; req0_a[1] = 16'h0007; req0_b[1] = 16'hFFFD;
        #1;
        checks++;
        if (req0_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept: got %0d expected 1", req0_ready[1]);
        end
        sb_push(1, 1'b0, 32'hFFFF_FFEB);
        cyc();
        req0_valid[1] = 1'b0;
        n = 1;
        while (n <= 16 && !rsp_valid[1]) begin
            cyc();
            n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL stall_latency: got %0d expected 4", n);
        end
        sid  = rsp_id[1];
        spro = rsp_pro[1];
        req1_valid[1] = 1'b1; req1_a[1] = 16'h0100; req1_b[1] = 16'h0002;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (rsp_valid[1] !== 1'b1 || rsp_id[1] !== sid || rsp_pro[1] !== spro ||
                req0_ready[1] !== 1'b0 || req1_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold c%0d: got v%0d id%0d pro %h rdy %0d/%0d expected v1 id%0d pro %h rdy 0/0",
                         c, rsp_valid[1], rsp_id[1], rsp_pro[1], req0_ready[1], req1_ready[1], sid, spro);
            end
            cyc();
        end
        rsp_ready[1] = 1'b1;
        #1;
        checks++;
        if (req1_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_grant: got %0d expected 1", req1_ready[1]);
        end
        sb_check(1, "stall_rsp");
        sb_push(1, 1'b1, 32'h0000_0200);
        cyc();
        req1_valid[1] = 1'b0;
        drain(1, 1, 20, 1'b0, "stall_next");
        rsp_ready[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        req0_valid[1] = 1'b1; req0_a[1] = 16'h0011; req0_b[1] = 16'h0022;
        #1;
        checks++;
        if (req0_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_accept: got %0d expected 1", req0_ready[1]);
        end
        cyc();
        req0_valid[1] = 1'b0;
        rst = 1'b1;
        cyc();
        check_zero_out(1, "rstmid_outputs");
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            cyc();
            if (rsp_valid[1]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rstmid_no_rsp: got rsp_valid 1 expected 0");
        end
        rsp_ready[1]  = 1'b1;
        req0_valid[1] = 1'b1; req0_a[1] = 16'h0011; req0_b[1] = 16'h0022;
        req1_valid[1] = 1'b1; req1_a[1] = 16'h0003; req1_b[1] = 16'hFFFE;
        #1;
        checks++;
        if (req0_ready[1] !== 1'b1 || req1_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_tie: got %0d/%0d expected 1/0", req0_ready[1], req1_ready[1]);
        end
        sb_push(1, 1'b0, 32'h0000_0242);
        sb_push(1, 1'b1, 32'hFFFF_FFFA);
        drain(1, 2, 40, 1'b0, "rstmid_after");
        rsp_ready[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int u = 0; u < 2; u++) begin
            rsp_ready[u]  = 1'b1;
            req0_valid[u] = 1'b1; req0_a[u] = 16'h8000; req0_b[u] = 16'h8000;
            req1_valid[u] = 1'b1; req1_a[u] = 16'h7FFF; req1_b[u] = 16'hFFFF;
            drain(u, 2, 40, 1'b1, "back_to_back");
            rsp_ready[u] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req0_valid[u] = 1'b0; req0_a[u] = 16'h0; req0_b[u] = 16'h0;
            req1_valid[u] = 1'b0; req1_a[u] = 16'h0; req1_b[u] = 16'h0;
            rsp_ready[u]  = 1'b0;
        end
        cyc();
        test_reset();
        test_single();
        test_zero_operand();
        test_tie_rr();
        test_hold_stall();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d/%0d left expected 0/0", sb0.size(), sb1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
